// File: rtl/lcd_spi_arbiter_if.sv
// Request-side bus of the LCD SPI arbiter: one byte lane plus handshake per requester.
interface lcd_spi_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_dc;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;

  modport master (
    output req_valid, req_data, req_dc, req_last,
    input  req_ready, grant
  );

  modport slave (
    input  req_valid, req_data, req_dc, req_last,
    output req_ready, grant
  );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Shares one LCD SPI link between NREQ byte-stream requesters, locking it per transaction.
// Define LCD_ARB_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module lcd_spi_arbiter #(
  parameter int NREQ   = 4,
  parameter int CS_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  lcd_spi_arbiter_if.slave bus,
  output logic             busy,
  output logic             lcd_cs,
  output logic             lcd_rs,
  output logic             lcd_data,
  output logic             lcd_clk
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SHIFT, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   pick, idx;
  logic            pick_ok;
  logic [NREQ-1:0] grant_r, grant_nxt;
  logic [NREQ-1:0] ready;
  logic [7:0]      shift, shift_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [3:0]      gap_cnt, gap_nxt;
  logic            last_r, last_nxt;
  logic            cs_r, cs_nxt;
  logic            rs_r, rs_nxt;
  logic            own_valid;
  logic            load;

  // Scan from the far end so the candidate closest to the pointer is written last and wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
`ifdef LCD_ARB_PRIORITY_EN
      idx = IW'(i);
`else
      idx = IW'((int'(rr_ptr) + i) % NREQ);
`endif
      if (bus.req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign own_valid = bus.req_valid[owner];

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    grant_nxt   = grant_r;
    ready       = '0;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    gap_nxt     = gap_cnt;
    last_nxt    = last_r;
    cs_nxt      = cs_r;
    rs_nxt      = rs_r;
    load        = 1'b0;

    case (state)
      IDLE: begin
        cs_nxt = 1'b1;
        if (pick_ok) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          owner_nxt       = pick;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        ready[owner] = own_valid;
        load         = own_valid;
      end
      SHIFT: begin
        shift_nxt   = {shift[6:0], 1'b1};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (!last_r) begin
            // Reloading on the last bit keeps bytes back to back with cs held low.
            ready[owner] = own_valid;
            load         = own_valid;
            if (!own_valid) state_nxt = HOLD;
          end else begin
            state_nxt = GAP;
            cs_nxt    = 1'b1;
            rs_nxt    = 1'b1;
            grant_nxt = '0;
            gap_nxt   = '0;
`ifdef LCD_ARB_PRIORITY_EN
            rr_nxt    = '0;
`else
            rr_nxt    = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
`endif
          end
        end
      end
      GAP: begin
        gap_nxt = gap_cnt + 4'd1;
        if (int'(gap_cnt) + 1 >= CS_GAP) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      shift_nxt   = bus.req_data[{owner, 3'b000} +: 8];
      rs_nxt      = bus.req_dc[owner];
      last_nxt    = bus.req_last[owner];
      cs_nxt      = 1'b0;
      bit_cnt_nxt = 3'd0;
      state_nxt   = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      grant_r <= '0;
      shift   <= 8'hFF;
      bit_cnt <= 3'd0;
      gap_cnt <= 4'd0;
      last_r  <= 1'b0;
      cs_r    <= 1'b1;
      rs_r    <= 1'b1;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_nxt;
      grant_r <= grant_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_nxt;
      last_r  <= last_nxt;
      cs_r    <= cs_nxt;
      rs_r    <= rs_nxt;
    end
  end

  // The serial clock is the inverted system clock, so the panel samples mid-bit on its rising edge.
  assign lcd_clk       = (state == SHIFT) ? ~clk : 1'b1;
  assign lcd_data      = (state == SHIFT) ? shift[7] : 1'b1;
  assign lcd_cs        = cs_r;
  assign lcd_rs        = rs_r;
  assign busy          = (state != IDLE);
  assign bus.grant     = grant_r;
  assign bus.req_ready = ready;

endmodule
